// File: rtl/retire_aligner.sv
// retire_aligner: buffers per-core retirement observations in two FIFOs and pairs them in program order.
// Emits one retire pulse per pair, counts pairs and records the first observation divergence.
module retire_aligner #(
    parameter int OBS_W = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     retire_1_i,
    input  logic [OBS_W-1:0]         obs_1_i,
    input  logic                     retire_2_i,
    input  logic [OBS_W-1:0]         obs_2_i,
    output logic                     retire_o,
    output logic [31:0]              pair_count_o,
    output logic                     mismatch_o,
    output logic [31:0]              mismatch_idx_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   level_1_o,
    output logic [$clog2(DEPTH):0]   level_2_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [OBS_W-1:0] mem [2][DEPTH];
    logic [OBS_W-1:0] obs [2];
    logic [OBS_W-1:0] head [2];
    logic [AW-1:0]    wr_ptr [2];
    logic [AW-1:0]    rd_ptr [2];
    logic [LW-1:0]    level [2];
    logic [1:0]       retire;
    logic [1:0]       push;
    logic             pop;

    assign retire = {retire_2_i, retire_1_i};
    assign obs[0] = obs_1_i;
    assign obs[1] = obs_2_i;
    assign pop = (level[0] != '0) && (level[1] != '0);

    // A full FIFO still accepts a push when it is popped at the same edge.
    for (genvar k = 0; k < 2; k++) begin : g_fifo
        assign push[k] = retire[k] && ((level[k] != LW'(DEPTH)) || pop);
        assign head[k] = mem[k][rd_ptr[k]];
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 2; k++)
            if (push[k]) mem[k][wr_ptr[k]] <= obs[k];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                level[k]  <= '0;
            end
            retire_o       <= 1'b0;
            pair_count_o   <= '0;
            mismatch_o     <= 1'b0;
            mismatch_idx_o <= '0;
            overflow_o     <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
                if (pop) rd_ptr[k] <= rd_ptr[k] + AW'(1);
                level[k] <= level[k] + LW'(push[k]) - LW'(pop);
            end
            retire_o <= pop;
            if (pop && pair_count_o != '1) pair_count_o <= pair_count_o + 32'd1;
            if (pop && head[0] != head[1] && !mismatch_o) begin
                mismatch_o     <= 1'b1;
                mismatch_idx_o <= pair_count_o;
            end
            if ((retire & ~push) != 2'b00) overflow_o <= 1'b1;
        end
    end

    assign level_1_o = level[0];
    assign level_2_o = level[1];
endmodule

// File: tb/tb_retire_aligner.sv
// tb_retire_aligner: scoreboard bench; expected pulses are queued as pairs are driven and
// matched against retire_o pulses, alongside directed status checks.
module tb_retire_aligner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r1 = 1'b0, r2 = 1'b0;
    logic [63:0] o1 = '0, o2 = '0;
    logic        retire;
    logic [31:0] pair_count, mismatch_idx;
    logic        mismatch, overflow;
    logic [3:0]  level_1, level_2;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        logic        mm;
    } exp_t;
    exp_t q[$];

    retire_aligner #(.OBS_W(64), .DEPTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .retire_1_i(r1), .obs_1_i(o1), .retire_2_i(r2), .obs_2_i(o2),
        .retire_o(retire), .pair_count_o(pair_count), .mismatch_o(mismatch),
        .mismatch_idx_o(mismatch_idx), .overflow_o(overflow),
        .level_1_o(level_1), .level_2_o(level_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && retire) begin
            if (q.size() == 0) check("unexpected_retire", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("retire_cycle", 64'(cyc), 64'(e.cyc));
                check("pulse_count", 64'(pair_count), 64'(e.cnt));
                check("pulse_mismatch", 64'(mismatch), 64'(e.mm));
            end
        end
    end

    task automatic drive(input logic a, input logic [63:0] x, input logic b, input logic [63:0] y);
        @(posedge clk);
        #1;
        r1 = a; o1 = x; r2 = b; o2 = y;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic expect_pulse(input logic [31:0] cnt, input logic mm);
        q.push_back('{cyc + 2, cnt, mm});
    endtask

    task automatic do_reset();
        check("drain_before_reset", 64'(q.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_retire", 64'(retire), 64'd0);
        check("rst_count", 64'(pair_count), 64'd0);
        check("rst_mismatch", 64'(mismatch), 64'd0);
        check("rst_idx", 64'(mismatch_idx), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_level_1", 64'(level_1), 64'd0);
        check("rst_level_2", 64'(level_2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset();
        // lockstep
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 64'(i), 1'b1, 64'(i));
            expect_pulse(32'(i), 1'b0);
        end
        idle(4);
        check("lock_count", 64'(pair_count), 64'd5);
        check("lock_mismatch", 64'(mismatch), 64'd0);
        check("lock_level_1", 64'(level_1), 64'd0);
        // skew
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 64'(10 + i), 1'b0, '0);
        idle(1);
        check("skew_level_1", 64'(level_1), 64'd3);
        check("skew_level_2", 64'(level_2), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 64'(10 + i));
            expect_pulse(32'(i + 1), 1'b0);
        end
        idle(4);
        check("skew_end_level_1", 64'(level_1), 64'd0);
        check("skew_end_level_2", 64'(level_2), 64'd0);
        check("skew_count", 64'(pair_count), 64'd3);
        // mismatch at pairs 2 and 4
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [63:0] v;
            v = 64'hA5A5_0000_0000_0000 | 64'(i);
            drive(1'b1, v, 1'b1, (i == 2 || i == 4) ? v ^ 64'd1 : v);
            expect_pulse(32'(i + 1), i >= 2);
        end
        idle(4);
        check("mm_flag", 64'(mismatch), 64'd1);
        check("mm_idx", 64'(mismatch_idx), 64'd2);
        check("mm_count", 64'(pair_count), 64'd5);
        // overflow
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 64'(100 + i), 1'b0, '0);
            if (i == 8) begin
                check("ovf_before", 64'(overflow), 64'd0);
                check("ovf_full_level", 64'(level_1), 64'd8);
            end
        end
        idle(1);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_level_1", 64'(level_1), 64'd8);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 64'(100 + i));
            expect_pulse(32'(i + 1), 1'b0);
        end
        idle(4);
        check("ovf_count", 64'(pair_count), 64'd8);
        check("ovf_mismatch", 64'(mismatch), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        // full push with simultaneous pop
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 64'(200 + i), 1'b0, '0);
        drive(1'b0, '0, 1'b1, 64'd200);
        expect_pulse(32'd1, 1'b0);
        drive(1'b1, 64'd208, 1'b0, '0);
        idle(3);
        check("fullpop_overflow", 64'(overflow), 64'd0);
        check("fullpop_level_1", 64'(level_1), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, '0, 1'b1, 64'(200 + i));
            expect_pulse(32'(i + 1), 1'b0);
        end
        idle(4);
        check("fullpop_count", 64'(pair_count), 64'd9);
        check("fullpop_mismatch", 64'(mismatch), 64'd0);
        // async reset mid-run
        do_reset();
        drive(1'b1, 64'd1, 1'b1, 64'd2);
        expect_pulse(32'd1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 64'(300 + i), 1'b0, '0);
        idle(3);
        check("mid_level_1", 64'(level_1), 64'd4);
        check("mid_mismatch", 64'(mismatch), 64'd1);
        do_reset();
        drive(1'b1, 64'd7, 1'b1, 64'd7);
        expect_pulse(32'd1, 1'b0);
        idle(4);
        check("post_level_1", 64'(level_1), 64'd0);
        check("drain_end", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
